// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file definitions for decode, writeback and the
// register file itself.
//   REG_WIDTH  : data word width
//   REG_AWIDTH : register-number width
//   REG_NREGS  : number of architectural registers
//   REG_ZERO   : register number of $zero
//   reg_num_t  : register number type
//   word_t     : data word type
package regfile_pkg;
  localparam int REG_WIDTH  = 32;
  localparam int REG_AWIDTH = 5;
  localparam int REG_NREGS  = 1 << REG_AWIDTH;

  typedef logic [REG_AWIDTH-1:0] reg_num_t;
  typedef logic [REG_WIDTH-1:0]  word_t;

  localparam reg_num_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_if.sv
// regfile_if: bundle of register-file read, write and reserve signals.
//   rs_num/rt_num     : read port register numbers (master -> slave)
//   rs_data/rt_data   : read data (slave -> master)
//   rs_busy/rt_busy   : busy bits of the read registers (slave -> master)
//   rd_num/rd_data/rd_we : writeback port (master -> slave)
//   resv_num/resv_en  : reservation strobe from issue (master -> slave)
// Modports: master = decode/writeback side, slave = register file.
interface regfile_if import regfile_pkg::*; #(
  parameter int WIDTH  = REG_WIDTH,
  parameter int AWIDTH = REG_AWIDTH
) ();
  logic [AWIDTH-1:0] rs_num;
  logic [AWIDTH-1:0] rt_num;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic              rs_busy;
  logic              rt_busy;
  logic [AWIDTH-1:0] rd_num;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_we;
  logic [AWIDTH-1:0] resv_num;
  logic              resv_en;

  modport master (
    output rs_num, rt_num, rd_num, rd_data, rd_we, resv_num, resv_en,
    input  rs_data, rt_data, rs_busy, rt_busy
  );

  modport slave (
    input  rs_num, rt_num, rd_num, rd_data, rd_we, resv_num, resv_en,
    output rs_data, rt_data, rs_busy, rt_busy
  );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
//   num      : register number to read
//   regs     : flattened storage array
//   busy_vec : per-register busy scoreboard
//   data     : register contents ($zero forced to 0)
//   busy     : busy bit ($zero never busy)
// With REGFILE_BYPASS_EN defined, extra inputs (reset, rd_we, rd_num, rd_data,
// resv_en, resv_num) forward a same-cycle write to the read data.
module regfile_read_port import regfile_pkg::*; #(
  parameter int WIDTH  = REG_WIDTH,
  parameter int NREGS  = REG_NREGS,
  parameter int AWIDTH = REG_AWIDTH
) (
  input  logic [AWIDTH-1:0]           num,
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic [NREGS-1:0]            busy_vec,
`ifdef REGFILE_BYPASS_EN
  input  logic                        reset,
  input  logic                        rd_we,
  input  logic [AWIDTH-1:0]           rd_num,
  input  logic [WIDTH-1:0]            rd_data,
  input  logic                        resv_en,
  input  logic [AWIDTH-1:0]           resv_num,
`endif
  output logic [WIDTH-1:0]            data,
  output logic                        busy
);

  always_comb begin
    data = regs[num];
    busy = busy_vec[num];
`ifdef REGFILE_BYPASS_EN
    // Retiring write is forwarded; busy only if a new producer reserves now.
    if (!reset && rd_we && (rd_num == num)) begin
      data = rd_data;
      busy = resv_en && (resv_num == num);
    end
`endif
    // $zero masking last so it also overrides any forwarding.
    if (num == '0) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32-bit MIPS-style register file with a per-register busy
// scoreboard for RAW hazard detection.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset (clears data and busy bits)
//   bus   : regfile_if.slave - two combinational read ports (rs, rt), one
//           clocked write port (rd) and one reservation strobe (resv)
// Optional macro REGFILE_BYPASS_EN: forward same-cycle writes to read ports.
module regfile import regfile_pkg::*; #(
  parameter int WIDTH  = REG_WIDTH,
  parameter int NREGS  = REG_NREGS,
  parameter int AWIDTH = REG_AWIDTH
) (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave bus
);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            busy;

  // Entry 0 is only ever reset, never written; reads mask it anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (bus.rd_we && (bus.rd_num != '0)) begin
        regs[bus.rd_num] <= bus.rd_data;
        busy[bus.rd_num] <= 1'b0;
      end
      // Later assignment wins: a reserve beats a same-register write clear.
      if (bus.resv_en && (bus.resv_num != '0)) begin
        busy[bus.resv_num] <= 1'b1;
      end
    end
  end

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .NREGS  (NREGS),
    .AWIDTH (AWIDTH)
  ) u_rs_port (
    .num      (bus.rs_num),
    .regs     (regs),
    .busy_vec (busy),
`ifdef REGFILE_BYPASS_EN
    .reset    (reset),
    .rd_we    (bus.rd_we),
    .rd_num   (bus.rd_num),
    .rd_data  (bus.rd_data),
    .resv_en  (bus.resv_en),
    .resv_num (bus.resv_num),
`endif
    .data     (bus.rs_data),
    .busy     (bus.rs_busy)
  );

  regfile_read_port #(
    .WIDTH  (WIDTH),
    .NREGS  (NREGS),
    .AWIDTH (AWIDTH)
  ) u_rt_port (
    .num      (bus.rt_num),
    .regs     (regs),
    .busy_vec (busy),
`ifdef REGFILE_BYPASS_EN
    .reset    (reset),
    .rd_we    (bus.rd_we),
    .rd_num   (bus.rd_num),
    .rd_data  (bus.rd_data),
    .resv_en  (bus.resv_en),
    .resv_num (bus.resv_num),
`endif
    .data     (bus.rt_data),
    .busy     (bus.rt_busy)
  );

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for regfile. The driver applies one set of
// inputs per cycle, updates a behavioural array model and queues the expected
// read-port values; the monitor pops and compares on the falling edge.
module tb_regfile;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_if #(.WIDTH(32), .AWIDTH(5)) bus ();

  regfile #(.WIDTH(32), .NREGS(32), .AWIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       nm;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic        rsb;
    logic        rtb;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: architectural contents and outstanding-producer flags.
  logic [31:0] mreg  [32];
  bit          mbusy [32];

  // Apply the effect of the edge that just consumed the current inputs.
  task automatic model_edge();
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        mreg[i]  = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (bus.rd_we && bus.rd_num != 0) begin
        mreg[bus.rd_num]  = bus.rd_data;
        mbusy[bus.rd_num] = 1'b0;
      end
      if (bus.resv_en && bus.resv_num != 0) mbusy[bus.resv_num] = 1'b1;
    end
  endtask

  task automatic expect_read(input logic [4:0] n, output logic [31:0] d, output logic b);
    d = (n == 0) ? 32'h0 : mreg[n];
    b = (n == 0) ? 1'b0 : mbusy[n];
`ifdef REGFILE_BYPASS_EN
    if (!reset && bus.rd_we && n != 0 && bus.rd_num == n) begin
      d = bus.rd_data;
      b = bus.resv_en && (bus.resv_num == n);
    end
`endif
  endtask

  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [31:0] dat, input logic we,
                     input logic [4:0] rv, input logic ren, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    reset        = r;
    bus.rs_num   = rs;
    bus.rt_num   = rt;
    bus.rd_num   = rd;
    bus.rd_data  = dat;
    bus.rd_we    = we;
    bus.resv_num = rv;
    bus.resv_en  = ren;
    e.nm = nm;
    expect_read(rs, e.rsd, e.rsb);
    expect_read(rt, e.rtd, e.rtb);
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: read ports are combinational, so an output is present every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".rs_data"}, bus.rs_data, e.rsd);
        chk({e.nm, ".rt_data"}, bus.rt_data, e.rtd);
        chk({e.nm, ".rs_busy"}, {31'b0, bus.rs_busy}, {31'b0, e.rsb});
        chk({e.nm, ".rt_busy"}, {31'b0, bus.rt_busy}, {31'b0, e.rtb});
      end
    end
  end

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    reset        = 1'b1;
    bus.rs_num   = '0;
    bus.rt_num   = '0;
    bus.rd_num   = '0;
    bus.rd_data  = '0;
    bus.rd_we    = 1'b0;
    bus.resv_num = '0;
    bus.resv_en  = 1'b0;

    cyc(1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "post_reset");

    // Random writes/reserves, then a reset and a full sweep of all registers.
    for (int unsigned i = 0; i < 20; i++)
      cyc(1'b0, rnd_reg(), rnd_reg(), 5'($urandom_range(1, 31)), $urandom, 1'b1,
          5'($urandom_range(1, 31)), 1'b1, "fill");
    cyc(1'b1, 5'd3, 5'd4, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, "reset_edge");
    for (int unsigned i = 0; i < 32; i++)
      cyc(1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "reset_sweep");

    // Basic write/read and $zero.
    cyc(1'b0, 5'd5, 5'd0, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd0, 1'b0, "wr5");
    cyc(1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 1'b0, "rd5_wr0");
    cyc(1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "rd_zero");

    // Scoreboard set and clear.
    cyc(1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 1'b0, 5'd9, 1'b1, "resv9");
    cyc(1'b0, 5'd9, 5'd9, 5'd9, 32'h0000_0042, 1'b1, 5'd0, 1'b0, "busy9_wr9");
    cyc(1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "clear9");

    // Same-cycle write and reserve of one register: reserve wins.
    cyc(1'b0, 5'd12, 5'd12, 5'd12, 32'hA5A5_A5A5, 1'b1, 5'd12, 1'b1, "wr_resv12");
    cyc(1'b0, 5'd12, 5'd12, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "chk12");

    // Write and reserve of different registers in one cycle.
    cyc(1'b0, 5'd6, 5'd7, 5'd6, 32'h0000_0066, 1'b1, 5'd7, 1'b1, "wr6_resv7");
    cyc(1'b0, 5'd6, 5'd7, 5'd0, 32'h0, 1'b0, 5'd7, 1'b1, "resv7_again");
    cyc(1'b0, 5'd6, 5'd7, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "chk6_7");

    // Same-cycle read of the write target.
    cyc(1'b0, 5'd3, 5'd3, 5'd3, 32'h0000_0011, 1'b1, 5'd0, 1'b0, "wr3_old");
    cyc(1'b0, 5'd3, 5'd0, 5'd3, 32'h0000_0007, 1'b1, 5'd0, 1'b0, "wr3_same");
    cyc(1'b0, 5'd3, 5'd0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "wr3_after");

    // Reset mid-operation discards write and reserve of reg 4.
    cyc(1'b0, 5'd4, 5'd0, 5'd4, 32'h0000_0044, 1'b1, 5'd4, 1'b1, "pre4");
    cyc(1'b1, 5'd4, 5'd4, 5'd4, 32'h0000_0099, 1'b1, 5'd4, 1'b1, "reset4");
    cyc(1'b0, 5'd4, 5'd4, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, "after_reset4");

    // Random traffic concentrated on a few registers to provoke collisions.
    for (int unsigned i = 0; i < 400; i++)
      cyc(($urandom_range(0, 49) == 0), rnd_reg(), rnd_reg(), rnd_reg(), $urandom,
          1'($urandom_range(0, 1)), rnd_reg(), 1'($urandom_range(0, 1)), "random");

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
